// File: rtl/call_stack.sv
// Return-address stack for the 19-bit CPU: CALL pushes the return PC, RET reads
// the top entry combinationally and drops it at the next edge.
module call_stack #(
  parameter int ADDR_W = 19,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] ret_addr,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  sp_reg, sp_next;
  logic              overflow_reg, overflow_next;
  logic              underflow_reg, underflow_next;
  logic              ovf_set, unf_set;
  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     sp_idx;

  assign empty   = (sp_reg == '0);
  assign full    = (sp_reg == CNT_W'(DEPTH));
  assign count   = sp_reg;
  assign sp_idx  = AW'(sp_reg);
  assign top_idx = sp_idx - AW'(1);

  // Gated on empty so a never-written slot can't leak onto the PC mux.
  assign ret_addr  = empty ? '0 : mem[top_idx];
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  always_comb begin
    sp_next = sp_reg;
    wr_en   = 1'b0;
    wr_idx  = '0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = sp_idx;
          sp_next = sp_reg + CNT_W'(1);
        end
      end
      2'b01: begin
        if (empty) unf_set = 1'b1;
        else       sp_next = sp_reg - CNT_W'(1);
      end
      2'b11: begin
        // RET+CALL replaces the top; on an empty stack the push still lands.
        wr_en = 1'b1;
        if (empty) begin
          wr_idx  = '0;
          sp_next = CNT_W'(1);
          unf_set = 1'b1;
        end else begin
          wr_idx = top_idx;
        end
      end
      default: ;
    endcase
    overflow_next  = (overflow_reg & ~clr_err) | ovf_set;
    underflow_next = (underflow_reg & ~clr_err) | unf_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_reg        <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      sp_reg        <= sp_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Entry storage carries no reset; validity is tracked by sp alone.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_idx] <= push_addr;
  end

endmodule
